// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache line fill controller: state encoding,
// default geometry and word/line offset widths.
package cache_fill_fsm_pkg;

    localparam int ADDR_W_DFLT     = 16;
    localparam int LINE_WORDS_DFLT = 8;
    localparam int WORD_W          = 16;
    localparam int WORD_OFF_W      = 1;   // byte offset inside a 16-bit word

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

    // Byte-offset width of a whole line: word index bits plus byte-in-word bit.
    function automatic int line_off_w(input int line_words);
        return $clog2(line_words) + WORD_OFF_W;
    endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Enable/clear up-counter that saturates at MAX; clear has priority over enable.
module fill_counter #(
    parameter int W   = 3,
    parameter int MAX = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss line-fill controller: issues one read per word of the line and
// writes returned words (arriving in order, any latency) into the data array.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DFLT,
    parameter int LINE_WORDS = LINE_WORDS_DFLT,
    localparam int IDX_W     = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [WORD_W-1:0] memory_data,
    output logic              fsm_busy,
    output logic              memory_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [IDX_W-1:0]  word_sel,
    output logic              write_tag_array,
    output logic [WORD_W-1:0] fill_data
);

    localparam int OFF_W  = line_off_w(LINE_WORDS);
    localparam int BASE_W = ADDR_W - OFF_W;
    // One extra bit lets the request counter park at LINE_WORDS, marking
    // "all requests issued" without wrapping back to word 0.
    localparam int REQ_W  = IDX_W + 1;

    fill_state_e       state_q, state_d;
    logic [BASE_W-1:0] base_q, base_d;
    logic [REQ_W-1:0]  req_cnt;
    logic [IDX_W-1:0]  rcv_cnt;
    logic              cnt_clr;
    logic              req_en;
    logic              busy;
    logic              unused_low_addr;

    assign unused_low_addr = ^miss_address[OFF_W-1:0];

    fill_counter #(.W(REQ_W), .MAX(LINE_WORDS)) u_req_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (req_en),
        .cnt   (req_cnt)
    );

    fill_counter #(.W(IDX_W), .MAX(LINE_WORDS - 1)) u_rcv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (write_data_array),
        .cnt   (rcv_cnt)
    );

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        busy             = 1'b0;
        memory_en        = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        word_sel         = '0;
        write_tag_array  = 1'b0;
        req_en           = 1'b0;
        cnt_clr          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Counters sit at zero so every fill starts from word 0.
                cnt_clr = 1'b1;
                if (miss_detected) begin
                    busy    = 1'b1;
                    state_d = ST_FILL;
                    base_d  = miss_address[ADDR_W-1:OFF_W];
                end
            end
            ST_FILL: begin
                busy = 1'b1;
                if (req_cnt != REQ_W'(LINE_WORDS)) begin
                    memory_en      = 1'b1;
                    memory_address = {base_q, req_cnt[IDX_W-1:0], 1'b0};
                    req_en         = 1'b1;
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    word_sel         = rcv_cnt;
                    if (rcv_cnt == IDX_W'(LINE_WORDS - 1)) begin
                        write_tag_array = 1'b1;
                        cnt_clr         = 1'b1;
                        state_d         = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    // Busy is combinational from miss_detected in IDLE, so hold it low in reset.
    assign fsm_busy  = busy & rst_n;
    assign fill_data = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a memory model answers reads with a
// programmable latency, a monitor pops expected requests/writes as they appear.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        memory_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  word_sel;
    logic        write_tag_array;
    logic [15:0] fill_data;

    cache_fill_fsm #(.ADDR_W(16), .LINE_WORDS(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .memory_en         (memory_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .word_sel          (word_sel),
        .write_tag_array   (write_tag_array),
        .fill_data         (fill_data)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] addr; int due; } mreq_t;
    typedef struct { logic [2:0] sel; logic [15:0] data; logic tag; } wr_t;

    mreq_t       mem_q[$];
    logic [15:0] exp_req[$];
    wr_t         exp_wr[$];

    int   total = 0, passed = 0;
    int   cyc = 0, lat = 4;
    int   wr_cnt = 0, tag_cnt = 0;
    logic alt_gap = 1'b0;
    logic force_valid = 1'b0;
    logic [15:0] force_data = 16'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic push_fill(input logic [15:0] base);
        for (int i = 0; i < 8; i++) begin
            logic [15:0] a;
            wr_t w;
            a = base + 16'(2 * i);
            exp_req.push_back(a);
            w.sel  = i[2:0];
            w.data = mem_word(a);
            w.tag  = (i == 7);
            exp_wr.push_back(w);
        end
    endtask

    task automatic wait_tag(input int target);
        int n = 0;
        while (tag_cnt < target && n < 300) begin step(); n++; end
        chk("wait_tag_timeout", tag_cnt >= target, 1);
    endtask

    task automatic wait_wr(input int target);
        int n = 0;
        while (wr_cnt < target && n < 300) begin step(); n++; end
        chk("wait_wr_timeout", wr_cnt >= target, 1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"},  fsm_busy, 0);
        chk({nm, "_men"},   memory_en, 0);
        chk({nm, "_maddr"}, memory_address, 0);
        chk({nm, "_wr"},    write_data_array, 0);
        chk({nm, "_sel"},   word_sel, 0);
        chk({nm, "_tag"},   write_tag_array, 0);
    endtask

    // Memory model: capture requests, return words in order after lat cycles.
    always @(negedge clk) begin
        if (memory_en) mem_q.push_back('{addr: memory_address, due: cyc + lat});
    end

    always @(posedge clk) begin
        logic pop;
        logic [15:0] d;
        cyc = cyc + 1;
        #1;
        pop = 1'b0;
        d   = force_data;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc && (!alt_gap || cyc[0])) begin
            pop = 1'b1;
            d   = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        memory_data_valid = pop | force_valid;
        memory_data       = d;
    end

    // Monitor: every DUT request/write must match the head of its queue.
    always @(negedge clk) begin
        if (memory_en) begin
            chk("mem_en_expected", exp_req.size() != 0, 1);
            if (exp_req.size() != 0) chk("mem_addr", memory_address, exp_req.pop_front());
        end
        if (write_data_array) begin
            wr_cnt++;
            chk("wr_expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("word_sel",  word_sel, e.sel);
                chk("fill_data", fill_data, e.data);
                chk("tag_flag",  write_tag_array, e.tag);
            end
        end
        if (write_tag_array) begin
            tag_cnt++;
            chk("tag_with_write", write_data_array, 1);
        end
    end

    initial begin
        int wr_base, tag_base;
        rst_n = 1'b0;
        miss_detected = 1'b1;
        miss_address  = 16'h5A5A;
        memory_data_valid = 1'b0;
        memory_data = 16'h0;
        force_valid = 1'b1;
        force_data  = 16'h1234;
        step(); step();
        #1 chk_all_zero("reset");
        rst_n = 1'b1; miss_detected = 1'b0; force_valid = 1'b0;
        step(); step();

        // Basic fill, latency 4
        push_fill(16'h1230);
        miss_detected = 1'b1; miss_address = 16'h1236;
        #1 chk("idle_miss_busy", fsm_busy, 1);
        chk("idle_miss_no_men", memory_en, 0);
        step();
        miss_detected = 1'b0;
        #1 chk("fill_first_addr_busy", fsm_busy, 1);
        wait_tag(1);
        #1 chk("busy_after_fill", fsm_busy, 0);
        chk("tags_fill1", tag_cnt, 1);

        // Valid on alternate cycles
        step();
        alt_gap = 1'b1;
        push_fill(16'h4A00);
        miss_detected = 1'b1; miss_address = 16'h4A0C;
        step();
        miss_detected = 1'b0;
        wait_tag(2);
        #1 chk("busy_after_gap_fill", fsm_busy, 0);
        repeat (5) step();
        chk("tags_gap_fill", tag_cnt, 2);
        chk("wr_gap_fill", wr_cnt, 16);
        alt_gap = 1'b0;

        // Miss held through fill, then back-to-back fill
        push_fill(16'h1230);
        push_fill(16'hFFF0);
        miss_detected = 1'b1; miss_address = 16'h1236;
        step();
        miss_address = 16'hFFFE;
        wait_tag(3);
        #1 chk("b2b_idle_busy", fsm_busy, 1);
        chk("b2b_idle_no_men", memory_en, 0);
        step();
        miss_detected = 1'b0;
        wait_tag(4);
        #1 chk("busy_after_b2b", fsm_busy, 0);
        repeat (3) step();
        chk("req_q_drained", exp_req.size(), 0);
        chk("wr_q_drained", exp_wr.size(), 0);

        // Reset after the third returned word
        wr_base = wr_cnt; tag_base = tag_cnt;
        push_fill(16'h2000);
        miss_detected = 1'b1; miss_address = 16'h2000;
        step();
        miss_detected = 1'b0;
        wait_wr(wr_base + 3);
        rst_n = 1'b0;
        exp_req.delete();
        exp_wr.delete();
        #1 chk_all_zero("mid_reset");
        step(); step();
        rst_n = 1'b1;
        repeat (15) step();
        chk("reset_no_more_wr", wr_cnt, wr_base + 3);
        chk("reset_no_tag", tag_cnt, tag_base);
        chk("reset_idle_busy", fsm_busy, 0);

        // Stray valids in IDLE
        for (int i = 0; i < 4; i++) begin
            force_valid = (i % 2 == 0);
            force_data  = 16'hBEEF + 16'(i);
            step();
            #1 chk("idle_valid_wr", write_data_array, 0);
            chk("idle_valid_tag", write_tag_array, 0);
            chk("idle_valid_busy", fsm_busy, 0);
        end
        force_valid = 1'b0;
        step();
        chk("idle_total_tags", tag_cnt, tag_base);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning byte-address width.
REQ-002 The block SHALL have parameter LINE_WORDS, default 8, meaning 16-bit words per cache line (power of two).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port miss_detected, input, 1 bit: cache miss on current access.
REQ-006 The block SHALL have port miss_address, input, ADDR_W bits: byte address of the missing access.
REQ-007 The block SHALL have port memory_data_valid, input, 1 bit: memory returns one word this cycle.
REQ-008 The block SHALL have port memory_data, input, 16 bits: returned word.
REQ-009 The block SHALL have port fsm_busy, output, 1 bit: fill in progress; pipeline stalls.
REQ-010 The block SHALL have port memory_en, output, 1 bit: read request issued this cycle.
REQ-011 The block SHALL have port memory_address, output, ADDR_W bits: word-aligned read address.
REQ-012 The block SHALL have port write_data_array, output, 1 bit: write memory_data into the line this cycle.
REQ-013 The block SHALL have port word_sel, output, log2(LINE_WORDS) bits: target word index for write_data_array.
REQ-014 The block SHALL have port write_tag_array, output, 1 bit: one-cycle pulse writing tag and valid bit.
REQ-015 The block SHALL have port fill_data, output, 16 bits: memory_data forwarded combinationally.

Function
REQ-016 The block SHALL implement two states: IDLE and FILL.
REQ-017 IDLE to FILL SHALL occur on a rising edge with miss_detected=1; the line base miss_address[ADDR_W-1:log2(2*LINE_WORDS)] SHALL be latched on that edge.
REQ-018 In FILL, the block SHALL assert memory_en for exactly LINE_WORDS consecutive cycles, starting the first cycle of FILL, one word per cycle.
REQ-019 memory_address SHALL be {latched base, req_cnt, 1'b0}, where req_cnt counts 0..LINE_WORDS-1 and saturates, with no wrap, once all requests are issued.
REQ-020 memory_address SHALL be 0 when memory_en=0.
REQ-021 Memory read latency is not fixed in this block; data SHALL be accepted solely on memory_data_valid=1 while in FILL.
REQ-022 On each accepted word, write_data_array SHALL be 1 and word_sel SHALL equal rcv_cnt in the same cycle; rcv_cnt SHALL increment on that edge.
REQ-023 Returned words SHALL be assumed to arrive in request order.
REQ-024 On the word with rcv_cnt=LINE_WORDS-1, write_tag_array SHALL pulse in the same cycle and the state SHALL return to IDLE on that edge.
REQ-025 fsm_busy SHALL equal 1 combinationally in IDLE when miss_detected=1, and SHALL be 1 throughout FILL including the final-word cycle.
REQ-026 fsm_busy SHALL be 0 in the cycle after the final word.
REQ-027 miss_detected while in FILL SHALL be ignored; the latched address SHALL NOT change.
REQ-028 memory_data_valid in IDLE SHALL be ignored, with no writes.
REQ-029 A miss in the cycle immediately after completion SHALL start a new fill with counters at 0.
REQ-030 All write outputs SHALL be 0 when not accepting data.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, req_cnt=0, rcv_cnt=0, and latched base=0.
REQ-032 During reset, outputs fsm_busy, memory_en, write_data_array and write_tag_array SHALL be 0, and memory_address and word_sel SHALL be 0.
REQ-033 Reset mid-fill SHALL abandon the fill with no tag write; any later in-flight memory_data_valid SHALL be ignored in IDLE.

Structure
REQ-034 State encoding and LINE_WORDS/offset-width constants SHALL reside in the shared CPU package.
REQ-035 Counters SHALL be built from a single sub-module fill_counter, a parameterised enable/clear counter instantiated twice (req and rcv).

Verification
REQ-036 Miss at 0x1236, memory latency 4 -> addresses 0x1230,0x1232..0x123E over 8 cycles; 8 writes with word_sel 0..7; write_tag_array in the cycle of the 8th valid; fsm_busy low the next cycle.
REQ-037 Valid gaps (valid on alternate cycles) -> 8 writes, word_sel strictly 0..7, single tag pulse, no extra memory_en.
REQ-038 miss_detected held high through the fill with address 0xFFFE -> no restart; addresses remain 0x1230 base; back-to-back second fill to 0xFFF0..0xFFFE immediately after.
REQ-039 rst_n low after the 3rd returned word -> outputs 0 at once; no tag write; subsequent valids ignored.
REQ-040 memory_data_valid pulses in IDLE -> write_data_array and write_tag_array stay 0, fsm_busy 0.
